// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch redirects, dmem wait/timeout sequencing.
// Latency: stall/flush outputs are combinational from state and inputs. Backpressure: dmem_ready low stalls the pipe.
// Optional HAZARD_PERF_EN adds 32-bit load-use, memory-wait and redirect counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_branch_taken,
  input  logic       mem_access,
  input  logic       dmem_ready,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       idex_stall,
  output logic       exmem_stall,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       memwb_flush,
  output logic       pc_redirect,
  output logic       mem_fault
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_mem_stalls,
  output logic [31:0] perf_flushes
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   wait_cnt_q;

  logic load_use, wait_cyc, in_fault, branch_act, lu_act;

  assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                    ((id_use_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                     (id_use_rs2 && (id_rs2_addr == ex_rd_addr)));

  // The cycle dmem_ready rises in MEM_WAIT is not a wait cycle: the pipe advances.
  assign wait_cyc   = ((state_q == RUN) && mem_access && !dmem_ready) ||
                      ((state_q == MEM_WAIT) && !dmem_ready);
  assign in_fault   = (state_q == FAULT);
  assign branch_act = (state_q == RUN) && !wait_cyc && ex_branch_taken;
  assign lu_act     = !in_fault && !wait_cyc && !branch_act && load_use;

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    pc_redirect = 1'b0;
    mem_fault   = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (in_fault) begin
      mem_fault   = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (wait_cyc) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
    end else if (branch_act) begin
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (lu_act) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_access && !dmem_ready) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
            state_q    <= FAULT;
          end else if (wait_cnt_q != '1) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        FAULT: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_mem_q, perf_br_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_q  <= '0;
      perf_mem_q <= '0;
      perf_br_q  <= '0;
    end else begin
      if (lu_act)     perf_lu_q  <= perf_lu_q + 32'd1;
      if (wait_cyc)   perf_mem_q <= perf_mem_q + 32'd1;
      if (branch_act) perf_br_q  <= perf_br_q + 32'd1;
    end
  end

  assign perf_lu_stalls  = perf_lu_q;
  assign perf_mem_stalls = perf_mem_q;
  assign perf_flushes    = perf_br_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_hazard_ctrl;
  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
  logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0;
  logic       ex_branch_taken = 0, mem_access = 0, dmem_ready = 1;
  logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_redirect, mem_fault;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_stalls, perf_mem_stalls, perf_flushes;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall), .exmem_stall(exmem_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .pc_redirect(pc_redirect), .mem_fault(mem_fault)
`ifdef HAZARD_PERF_EN
    , .perf_lu_stalls(perf_lu_stalls), .perf_mem_stalls(perf_mem_stalls), .perf_flushes(perf_flushes)
`endif
  );

  // {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_redirect, mem_fault}
  logic [9:0] obs;
  assign obs = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush,
                exmem_flush, memwb_flush, pc_redirect, mem_fault};

  localparam logic [9:0] V_IDLE  = 10'b0000000000;
  localparam logic [9:0] V_RST   = 10'b0000111100;
  localparam logic [9:0] V_FAULT = 10'b0000001101;
  localparam logic [9:0] V_WAIT  = 10'b1111000100;
  localparam logic [9:0] V_BR    = 10'b0000110010;
  localparam logic [9:0] V_LU    = 10'b1100010000;

  int checks = 0;
  int errors = 0;

  // Reference model: number of consecutive wait cycles so far, plus a pending fault cycle.
  int          m_waits = 0;
  bit          m_fault = 0;
  int unsigned m_lu = 0, m_mem = 0, m_br = 0;

  function automatic bit m_hazard();
    return ex_mem_read && (ex_rd_addr != 0) &&
           ((id_use_rs1 && id_rs1_addr == ex_rd_addr) || (id_use_rs2 && id_rs2_addr == ex_rd_addr));
  endfunction

  function automatic bit m_wait();
    if (m_fault) return 1'b0;
    if (m_waits > 0) return !dmem_ready;
    return mem_access && !dmem_ready;
  endfunction

  function automatic bit m_branch();
    return !m_fault && (m_waits == 0) && !m_wait() && ex_branch_taken;
  endfunction

  function automatic bit m_lu_act();
    return !m_fault && !m_wait() && !m_branch() && m_hazard();
  endfunction

  function automatic logic [9:0] exp_out();
    if (rst)        return V_RST;
    if (m_fault)    return V_FAULT;
    if (m_wait())   return V_WAIT;
    if (m_branch()) return V_BR;
    if (m_lu_act()) return V_LU;
    return V_IDLE;
  endfunction

  // Advance the model across the coming rising edge, then move to 1 time unit past it.
  task automatic tick();
    bit w;
    if (rst) begin
      m_waits = 0; m_fault = 0; m_lu = 0; m_mem = 0; m_br = 0;
    end else begin
      w = m_wait();
      if (m_lu_act()) m_lu++;
      if (w) m_mem++;
      if (m_branch()) m_br++;
      if (m_fault) begin
        m_fault = 0;
        m_waits = 0;
      end else if (w) begin
        m_waits++;
        if (m_waits == MEM_TIMEOUT + 1) begin
          m_fault = 1;
          m_waits = 0;
        end
      end else begin
        m_waits = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic mr, input logic [4:0] rd, input logic br, input logic ma,
                        input logic rdy);
    id_rs1_addr = rs1; id_rs2_addr = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_mem_read = mr; ex_rd_addr = rd; ex_branch_taken = br; mem_access = ma; dmem_ready = rdy;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== V_RST) begin errors++; $display("FAIL reset_hold obs=%b exp=%b", obs, V_RST); end
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL reset_release obs=%b exp=%b", obs, V_IDLE); end
    tick();
  endtask

  task automatic test_load_use();
    set_in(5, 1, 1, 1, 1, 5, 0, 0, 1); #3;
    checks++;
    if (obs !== V_LU) begin errors++; $display("FAIL lu_rs1 obs=%b exp=%b", obs, V_LU); end
    tick();
    set_in(5, 1, 1, 1, 0, 0, 0, 0, 1); #3;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL lu_after obs=%b exp=%b", obs, V_IDLE); end
    tick();
    set_in(0, 0, 1, 0, 1, 0, 0, 0, 1); #3;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL lu_x0 obs=%b exp=%b", obs, V_IDLE); end
    tick();
    set_in(7, 3, 0, 1, 1, 7, 0, 0, 1); #3;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL lu_rs2_nomatch obs=%b exp=%b", obs, V_IDLE); end
    tick();
    set_in(2, 7, 0, 1, 1, 7, 0, 0, 1); #3;
    checks++;
    if (obs !== V_LU) begin errors++; $display("FAIL lu_rs2 obs=%b exp=%b", obs, V_LU); end
    tick();
    for (int i = 0; i < 200; i++) begin
      set_in(5'($urandom % 4), 5'($urandom % 4), 1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom % 4), 1'(($urandom % 8) == 0), 1'b0, 1'b1);
      #3;
      checks++;
      if (obs !== exp_out()) begin errors++; $display("FAIL lu_rand cyc=%0d obs=%b exp=%b", i, obs, exp_out()); end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    int nwait = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(5, 0, 1, 0, 1, 5, 0, 1, 0);  // pending load-use must stay hidden behind the wait
      #3;
      checks++;
      if (obs !== V_WAIT) begin errors++; $display("FAIL wait_cyc%0d obs=%b exp=%b", i, obs, V_WAIT); end
      else nwait++;
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); #3;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL wait_exit obs=%b exp=%b", obs, V_IDLE); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); #3;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL wait_after obs=%b exp=%b", obs, V_IDLE); end
    checks++;
    if (nwait != 3) begin errors++; $display("FAIL wait_count got=%0d exp=3", nwait); end
    tick();
  endtask

  task automatic test_timeout();
    int nwait = 0;
    bit seen = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 40 && !seen; i++) begin
      #3;
      checks++;
      if (obs !== exp_out()) begin errors++; $display("FAIL timeout_cyc%0d obs=%b exp=%b", i, obs, exp_out()); end
      if (obs === V_WAIT) nwait++;
      if (obs === V_FAULT) seen = 1;
      tick();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL timeout_fault got=0 exp=1"); end
    checks++;
    if (nwait != MEM_TIMEOUT + 1) begin errors++; $display("FAIL timeout_waits got=%0d exp=%0d", nwait, MEM_TIMEOUT + 1); end
    mem_access = 1'b0; #3;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL after_fault obs=%b exp=%b", obs, V_IDLE); end
    tick();
  endtask

  task automatic test_branch();
    set_in(5, 0, 1, 0, 1, 5, 1, 0, 1); #3;
    checks++;
    if (obs !== V_BR) begin errors++; $display("FAIL br_over_lu obs=%b exp=%b", obs, V_BR); end
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); #3;
      checks++;
      if (obs !== V_WAIT) begin errors++; $display("FAIL br_in_wait%0d obs=%b exp=%b", i, obs, V_WAIT); end
      tick();
    end
    dmem_ready = 1'b1; #3;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL br_exit obs=%b exp=%b", obs, V_IDLE); end
    tick();
    mem_access = 1'b0; #3;
    checks++;
    if (obs !== V_BR) begin errors++; $display("FAIL br_after_exit obs=%b exp=%b", obs, V_BR); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_reset_mid_wait();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1; #3;
    checks++;
    if (obs !== V_RST) begin errors++; $display("FAIL rst_async obs=%b exp=%b", obs, V_RST); end
    tick();
    #2 rst = 1'b0; mem_access = 1'b0;
    #1;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL rst_release obs=%b exp=%b", obs, V_IDLE); end
`ifdef HAZARD_PERF_EN
    checks++;
    if (perf_lu_stalls !== 0 || perf_mem_stalls !== 0 || perf_flushes !== 0) begin
      errors++;
      $display("FAIL perf_reset got=%0d/%0d/%0d exp=0/0/0", perf_lu_stalls, perf_mem_stalls, perf_flushes);
    end
`endif
    tick();
    for (int i = 0; i < 20; i++) begin
      #3;
      checks++;
      if (obs !== V_IDLE) begin errors++; $display("FAIL rst_no_fault cyc=%0d obs=%b exp=%b", i, obs, V_IDLE); end
      tick();
    end
  endtask

  task automatic test_random();
    bit slow;
    for (int i = 0; i < 3000; i++) begin
      slow = ((i / 300) % 4) == 3;
      set_in(5'($urandom % 4), 5'($urandom % 4), 1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom % 4), 1'(($urandom % 6) == 0), 1'(($urandom % 3) == 0),
             1'(($urandom % 100) < (slow ? 3 : 60)));
      #3;
      checks++;
      if (obs !== exp_out()) begin errors++; $display("FAIL rand cyc=%0d obs=%b exp=%b", i, obs, exp_out()); end
      tick();
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (perf_lu_stalls !== m_lu) begin errors++; $display("FAIL perf_lu got=%0d exp=%0d", perf_lu_stalls, m_lu); end
    checks++;
    if (perf_mem_stalls !== m_mem) begin errors++; $display("FAIL perf_mem got=%0d exp=%0d", perf_mem_stalls, m_mem); end
    checks++;
    if (perf_flushes !== m_br) begin errors++; $display("FAIL perf_br got=%0d exp=%0d", perf_flushes, m_br); end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_branch();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
